// File: rtl/mmio_out_port.sv
// mmio_out_port: memory-mapped GPIO register plus a buffered 8N1 UART transmitter,
// with a pollable status word returned on the load path.
module mmio_out_port #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [31:0] GPIO_ADDR    = 32'h1001_0024,
    parameter logic [31:0] TX_ADDR      = 32'h1001_0028,
    parameter logic [31:0] STAT_ADDR    = 32'h1001_002C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wr_data_i,
    output logic [31:0] rd_data_o,
    output logic [7:0]  gpio_o,
    output logic        tx_o,
    output logic        tx_busy_o
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d, hold_q, hold_d, gpio_q, gpio_d;
    logic          hold_full_q, hold_full_d, ovf_q, ovf_d, tx_q, tx_d;
    logic          gpio_wr, tx_wr, stat_wr, deq, accept, bit_end;

    always_comb begin
        gpio_wr     = wr_en_i && addr_i == GPIO_ADDR;
        tx_wr       = wr_en_i && addr_i == TX_ADDR;
        stat_wr     = wr_en_i && addr_i == STAT_ADDR;
        deq         = state_q == IDLE && hold_full_q;
        // a full buffer still accepts when it is being drained at the same edge
        accept      = tx_wr && (!hold_full_q || deq);
        bit_end     = baud_q == BAUD_MAX;
        gpio_d      = gpio_wr ? wr_data_i[7:0] : gpio_q;
        hold_d      = accept ? wr_data_i[7:0] : hold_q;
        hold_full_d = accept || (hold_full_q && !deq);
        ovf_d       = (tx_wr && !accept) || (ovf_q && !stat_wr);
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        if (state_q == IDLE) begin
            if (deq) begin
                state_d = START;
                shift_d = hold_q;
                bit_d   = '0;
                baud_d  = '0;
            end
        end else begin
            baud_d = bit_end ? '0 : baud_q + BW'(1);
            if (bit_end) begin
                if (state_q == START) begin
                    state_d = DATA;
                end else if (state_q == STOP) begin
                    state_d = IDLE;
                end else begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    state_d = bit_q == 3'd7 ? STOP : DATA;
                end
            end
        end
        // line level is registered from the next state so tx_o never glitches
        tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ovf_q       <= 1'b0;
            gpio_q      <= '0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ovf_q       <= ovf_d;
            gpio_q      <= gpio_d;
            tx_q        <= tx_d;
        end
    end

    always_comb begin
        rd_data_o = addr_i == STAT_ADDR ? {29'b0, ovf_q, hold_full_q, state_q != IDLE} :
                    addr_i == GPIO_ADDR ? {24'b0, gpio_q} : 32'b0;
    end

    assign gpio_o    = gpio_q;
    assign tx_o      = tx_q;
    assign tx_busy_o = state_q != IDLE || hold_full_q;
endmodule

// File: tb/tb_mmio_out_port.sv
// tb_mmio_out_port: random and directed stores checked against a cycle-timed
// reference model; a serial monitor decodes tx_o and pops expected frames.
module tb_mmio_out_port;
    localparam int          CPB  = 4;
    localparam logic [31:0] GPIO = 32'h1001_0024;
    localparam logic [31:0] TX   = 32'h1001_0028;
    localparam logic [31:0] STAT = 32'h1001_002C;

    logic        clk, reset, wr_en_i, tx_o, tx_busy_o;
    logic [31:0] addr_i, wr_data_i, rd_data_o;
    logic [7:0]  gpio_o;

    mmio_out_port #(.CLKS_PER_BIT(CPB), .GPIO_ADDR(GPIO), .TX_ADDR(TX), .STAT_ADDR(STAT)) dut (
        .clk(clk), .reset(reset), .wr_en_i(wr_en_i), .addr_i(addr_i), .wr_data_i(wr_data_i),
        .rd_data_o(rd_data_o), .gpio_o(gpio_o), .tx_o(tx_o), .tx_busy_o(tx_busy_o)
    );

    typedef struct {
        logic [7:0] b;
        int         c;
    } frame_t;

    frame_t     exp_q[$];
    int         checks = 0, errors = 0;
    int         cyc = 0, idle_at = 0;
    logic       m_full = 0, m_ovf = 0;
    logic [7:0] m_byte = 0, m_gpio = 0;
    bit         mon_in_frame = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic m_fsm_busy();
        return cyc < idle_at - 1;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return a == STAT ? {29'b0, m_ovf, m_full, m_fsm_busy()} : a == GPIO ? {24'b0, m_gpio} : 32'b0;
    endfunction

    // Reference model: a frame occupies 10*CPB edges from its dequeue edge, and the
    // next dequeue can happen no earlier than one idle edge after that.
    initial begin
        logic deq, tx_wr, accept;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_full = 0; m_ovf = 0; m_gpio = 0; idle_at = 0;
                exp_q.delete();
            end else begin
                cyc++;
                deq    = cyc >= idle_at && m_full;
                tx_wr  = wr_en_i && addr_i == TX;
                accept = tx_wr && (!m_full || deq);
                if (deq) begin
                    exp_q.push_back('{m_byte, cyc});
                    idle_at = cyc + 10 * CPB + 1;
                    m_full  = 0;
                end
                if (accept) begin
                    m_byte = wr_data_i[7:0];
                    m_full = 1;
                end
                if (tx_wr && !accept) m_ovf = 1;
                else if (wr_en_i && addr_i == STAT) m_ovf = 0;
                if (wr_en_i && addr_i == GPIO) m_gpio = wr_data_i[7:0];
            end
        end
    end

    // Monitor: registers every cycle, plus serial decode of each frame on tx_o.
    initial begin
        frame_t f;
        int p, bi;
        logic eb;
        p = 0;
        f = '{8'h00, 0};
        forever begin
            @(negedge clk);
            #1;
            check("gpio_o", 32'(gpio_o), 32'(m_gpio));
            check("tx_busy_o", 32'(tx_busy_o), 32'(m_full || m_fsm_busy()));
            check("rd_data_o", rd_data_o, exp_rd(addr_i));
            if (!reset) begin
                mon_in_frame = 0;
            end else begin
                if (!mon_in_frame && tx_o === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_frame: tx_o low with no frame expected at cycle %0d", cyc);
                    end else begin
                        f = exp_q.pop_front();
                        check("start_cycle", cyc, f.c);
                        mon_in_frame = 1;
                        p = 0;
                    end
                end
                if (mon_in_frame) begin
                    bi = p / CPB;
                    eb = bi == 0 ? 1'b0 : bi == 9 ? 1'b1 : f.b[bi-1];
                    check("tx_bit", 32'(tx_o), 32'(eb));
                    p++;
                    if (p == 10 * CPB) mon_in_frame = 0;
                end
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en_i = 1; addr_i = a; wr_data_i = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            wr_en_i = 0; addr_i = STAT;
        end
    endtask

    task automatic step(input logic [31:0] a);
        @(negedge clk);
        wr_en_i = 0; addr_i = a;
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        wr_en_i = 0; addr_i = STAT;
        #2 reset = 0;
        #1;
        check("rst_tx_o", 32'(tx_o), 32'd1);
        check("rst_tx_busy_o", 32'(tx_busy_o), 32'd0);
        check("rst_gpio_o", 32'(gpio_o), 32'd0);
        check("rst_status", rd_data_o, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1;
    endtask

    initial begin
        int n, r;
        logic [31:0] other [3];
        other[0] = 32'h1001_0020; other[1] = 32'h1001_0029; other[2] = 32'h2001_0028;
        reset = 0; wr_en_i = 0; addr_i = STAT; wr_data_i = 0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_tx_o", 32'(tx_o), 32'd1);
        check("reset_gpio_o", 32'(gpio_o), 32'd0);
        check("reset_busy", 32'(tx_busy_o), 32'd0);
        check("reset_status", rd_data_o, 32'd0);
        @(negedge clk);
        reset = 1;
        idle(2);

        wr(GPIO, 32'h0000_00C3);
        step(GPIO);
        check("gpio_c3", 32'(gpio_o), 32'hC3);
        check("rd_gpio_c3", rd_data_o, 32'h0000_00C3);
        step(TX);
        check("rd_tx_zero", rd_data_o, 32'd0);

        idle(5);
        wr(TX, 32'hA5);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            step(STAT);
            if (k == 0) check("status_held", rd_data_o, 32'h2);
            if (k == 1) check("start_bit_latency", 32'(tx_o), 32'd0);
            if (!tx_busy_o) break;
            n++;
        end
        check("busy_len", n, 41);

        idle(5);
        wr(TX, 32'h11);
        wr(TX, 32'h22);
        step(STAT);
        check("b2b_status", rd_data_o, 32'h3);
        idle(100);

        wr(TX, 32'h01);
        wr(TX, 32'h02);
        wr(TX, 32'h03);
        step(STAT);
        check("overflow_set", rd_data_o, 32'h7);
        wr(STAT, 32'hFFFF_FFFF);
        step(STAT);
        check("overflow_clr", rd_data_o, 32'h3);
        idle(100);

        wr(TX, 32'h5A);
        idle(18);
        pulse_reset();
        idle(60);
        wr(GPIO, 32'h3C);
        idle(2);

        wr(TX, 32'h81);
        wr(TX, 32'h42);
        idle(40);
        wr(TX, 32'h24);
        step(STAT);
        check("same_edge_accept", rd_data_o, 32'h3);
        idle(150);

        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 15));
            if (r < 5) wr(TX, $urandom);
            else if (r < 7) wr(GPIO, $urandom);
            else if (r < 8) wr(STAT, $urandom);
            else if (r < 9) wr(other[$urandom_range(0, 2)], $urandom);
            else if (r < 11) step(r == 9 ? GPIO : other[$urandom_range(0, 2)]);
            else idle(int'($urandom_range(1, 60)));
            if (i % 500 == 250) pulse_reset();
        end
        idle(200);
        check("all_frames_seen", exp_q.size(), 0);
        check("no_frame_open", 32'(mon_in_frame), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmio_out_port.md
Name: mmio_out_port

Overview:
- Memory-mapped output peripheral downstream of the multicycle datapath.
- Consumes the datapath's store traffic: memory write enable, ALU-computed address and register-B write data.
- Drives an 8-bit GPIO register and a byte-wide UART transmitter with a one-entry holding buffer.
- Returns a status word that the datapath's load path muxes in for polling.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 2.
- GPIO_ADDR, 32'h1001_0024, word address of the GPIO output register.
- TX_ADDR, 32'h1001_0028, word address of the UART transmit data register.
- STAT_ADDR, 32'h1001_002C, word address of the status register.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_en_i  input  1  store strobe from control unit, one cycle per store.
- addr_i  input  32  byte address; full 32-bit compare against the address parameters.
- wr_data_i  input  32  store data.
- rd_data_o  output  32  combinational read data for addr_i.
- gpio_o  output  8  registered GPIO value.
- tx_o  output  1  UART serial line; idle high.
- tx_busy_o  output  1  high while a frame is in flight or the holding buffer is full.

Behaviour:
Reset (reset==0, asynchronous, any time, including mid-frame):
- gpio_o=0, tx_o=1, holding buffer empty, overflow=0, FSM=IDLE, counters=0.
- Any frame in progress is abandoned immediately; no partial stop bit.

GPIO:
- Write with wr_en_i=1 and addr_i==GPIO_ADDR loads wr_data_i[7:0] at the edge.
- gpio_o shows the new value the cycle after the edge.

Holding buffer:
- Write with wr_en_i=1 and addr_i==TX_ADDR is accepted when hold_full==0, or when the FSM dequeues at that same edge.
- An accepted write loads hold_byte=wr_data_i[7:0] and sets hold_full.
- Otherwise the write is dropped, hold_byte is unchanged, and the sticky overflow flag sets.
- Write to STAT_ADDR (any data) clears overflow. A simultaneous overflow event wins, so overflow stays 1.

UART FSM: IDLE, START, DATA, STOP. Format 8N1, LSB first.
- IDLE: tx_o=1. If hold_full, the next edge loads the shift register from hold_byte, clears hold_full (unless refilled at that edge), zeroes bit_cnt and baud_cnt, and goes to START.
- START: tx_o=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx_o=shift[0]; every CLKS_PER_BIT cycles, shift right and bit_cnt++. After 8 bits go to STOP.
- STOP: tx_o=1 for CLKS_PER_BIT cycles, then IDLE.
- Back-to-back frames: exactly one IDLE cycle separates the stop bit from the next start bit.
- baud_cnt counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- tx_o is driven directly from a flop; no combinational glitch.

Status and read data:
- tx_busy_o = (FSM!=IDLE) | hold_full.
- rd_data_o:
  - addr_i==STAT_ADDR: {29'b0, overflow, hold_full, FSM!=IDLE}.
  - addr_i==GPIO_ADDR: {24'b0, gpio_o}.
  - Any other address: 0. TX_ADDR is write-only and reads as 0.
- rd_data_o is independent of wr_en_i.

Other:
- Writes to unmapped addresses have no effect.
- Latency from TX write edge to the start bit falling edge: 1 clock.
- Frame length: 10*CLKS_PER_BIT cycles.

Test Plan:
1. Reset then release; write 0x0000_00C3 to GPIO_ADDR -> gpio_o=0xC3 the next cycle. Read GPIO_ADDR -> rd_data_o=0x0000_00C3.
2. CLKS_PER_BIT=4; write 0xA5 to TX_ADDR -> after 1 cycle tx_o sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1. tx_busy_o is high for 41 cycles, then low.
3. CLKS_PER_BIT=4; write 0x11, then 0x22 one cycle later -> second byte held, status reads 0x2 then 0x3 during the frame. Frames back-to-back with exactly one idle-high cycle between them. overflow=0.
4. Write three bytes on consecutive cycles during the first frame -> third byte dropped, status bit2=1. Write STAT_ADDR -> status bit2=0. Only two frames appear on tx_o.
5. Assert reset low during DATA bit 3 of a frame -> tx_o=1 asynchronously, tx_busy_o=0, gpio_o=0. After release, no residual frame appears.
6. Write to TX_ADDR on the same edge the FSM dequeues the held byte -> write accepted, no overflow, both bytes transmitted in order.
